// File: rtl/gnrl_pipe_fifo.sv
// rtl/gnrl_pipe_fifo.sv - DP-entry valid/ready buffering stage with optional same-cycle bypass (GNRL_PIPE_FIFO_BYPASS_EN)
module gnrl_pipe_fifo #(
  parameter int DW        = 32,
  parameter int DP        = 2,
  parameter int CUT_READY = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_vld,
  output logic                       i_rdy,
  input  logic [DW-1:0]              i_dat,
  output logic                       o_vld,
  input  logic                       o_rdy,
  output logic [DW-1:0]              o_dat,
  output logic [$clog2(DP+1)-1:0]    cnt,
  output logic                       full,
  output logic                       empty
);

  // Pointer width stays at least one bit so DP=1 still has a legal index.
  localparam int PW = (DP > 1) ? $clog2(DP) : 1;
  localparam int CW = $clog2(DP + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DP - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DP);

  logic [DW-1:0] mem [DP];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt;
  logic          push;
  logic          pop;

  // Pointers wrap with an explicit compare so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_r == CNT_FULL);
  assign empty = (cnt_r == '0);
  assign cnt   = cnt_r;

  // Ready cutting: CUT_READY=1 keeps i_rdy off the o_rdy path entirely.
  generate
    if (CUT_READY != 0) begin : g_cut_ready
      assign i_rdy = ~full;
    end else begin : g_pass_ready
      assign i_rdy = ~full | o_rdy;
    end
  endgenerate

`ifdef GNRL_PIPE_FIFO_BYPASS_EN
  // An empty stage presents the incoming beat directly; if it is taken the
  // same cycle it never touches the array, otherwise it is stored and held.
  always_comb begin
    o_vld = ~empty | i_vld;
    o_dat = empty ? i_dat : mem[rptr];
    push  = i_vld & i_rdy & ~(empty & o_rdy);
    pop   = ~empty & o_rdy;
  end
`else
  // Registered-only output: a beat is visible one cycle after it is pushed.
  always_comb begin
    o_vld = ~empty;
    o_dat = mem[rptr];
    push  = i_vld & i_rdy;
    pop   = o_vld & o_rdy;
  end
`endif

  // Occupancy moves by push minus pop; simultaneous push+pop leaves it alone.
  always_comb begin
    cnt_nxt = cnt_r + CW'(push) - CW'(pop);
  end

  // Control state: reset discards any in-flight entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt_r <= '0;
    end else begin
      if (push) begin
        wptr <= ptr_inc(wptr);
      end
      if (pop) begin
        rptr <= ptr_inc(rptr);
      end
      cnt_r <= cnt_nxt;
    end
  end

  // Storage array is written only on push and is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= i_dat;
    end
  end

endmodule
